// File: rtl/key_event_pkg.sv
// Shared types for the keycode event queue: event record, "no key" code, FSM states.
package key_event_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;

    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH_REL = 2'd1,
        PUSH_PRS = 2'd2
    } kq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: head is always presented on dout, count carries
// an extra bit so full is simply count == DEPTH. No write-to-read bypass.
module sync_fifo
    import key_event_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = key_evt_t
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // Pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; storage itself is not reset since empty masks its contents.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/keycode_event_queue.sv
// Debounces the raw keycode, converts accepted changes into release/press events,
// queues them in a FIFO, and provides a one-cycle frame strobe from vsync.
module keycode_event_queue
    import key_event_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [7:0]             keycode_in,
    input  logic                   vs,
    input  logic                   evt_ready,
    output logic                   evt_valid,
    output logic                   evt_press,
    output logic [7:0]             evt_code,
    output logic [7:0]             held_key,
    output logic                   frame_pulse,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] evt_count
);

    localparam int             CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  STABLE_MAX = CW'(STABLE_CYCLES);

    kq_state_t      state_q, state_d;
    logic [7:0]     candidate_q, candidate_d;
    logic [CW-1:0]  stable_cnt_q, stable_cnt_d;
    logic [7:0]     prev_key_q, prev_key_d;
    logic [7:0]     new_key_q, new_key_d;
    logic [7:0]     rel_key_q, rel_key_d;
    logic           overflow_q, overflow_d;
    logic           vs_d_q;
    logic           accept;
    logic           fifo_push;
    key_evt_t       fifo_din;
    key_evt_t       fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;

    // Debounce: track the last sample and how long it has been steady.
    always_comb begin
        candidate_d  = keycode_in;
        stable_cnt_d = stable_cnt_q;
        if (keycode_in != candidate_q) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q != STABLE_MAX) begin
            stable_cnt_d = stable_cnt_q + CW'(1);
        end
    end

    // A steady value that differs from the last accepted key is taken only while idle,
    // so changes arriving during a push sequence are re-judged against the updated key.
    assign accept = (stable_cnt_q == STABLE_MAX) && (candidate_q != prev_key_q) && (state_q == IDLE);

    // Key bookkeeping: remember old key for the release and new key for the press.
    always_comb begin
        prev_key_d = prev_key_q;
        new_key_d  = new_key_q;
        rel_key_d  = rel_key_q;
        if (accept) begin
            prev_key_d = candidate_q;
            new_key_d  = candidate_q;
            rel_key_d  = prev_key_q;
        end
    end

    // FSM next state: release of the old key (if any), then press of the new key (if any).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (prev_key_q != KEY_NONE) ? PUSH_REL : PUSH_PRS;
            end
            PUSH_REL: state_d = (new_key_q != KEY_NONE) ? PUSH_PRS : IDLE;
            PUSH_PRS: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: one FIFO push per PUSH_* cycle.
    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = '{press: 1'b0, code: KEY_NONE};
        case (state_q)
            PUSH_REL: begin
                fifo_push = 1'b1;
                fifo_din  = '{press: 1'b0, code: rel_key_q};
            end
            PUSH_PRS: begin
                fifo_push = 1'b1;
                fifo_din  = '{press: 1'b1, code: new_key_q};
            end
            default: ;
        endcase
    end

    // Overflow is sticky: set whenever a push is refused because the FIFO is full.
    assign overflow_d = overflow_q | (fifo_push && fifo_full && !evt_ready);

    // State register and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            candidate_q  <= KEY_NONE;
            stable_cnt_q <= '0;
            prev_key_q   <= KEY_NONE;
            new_key_q    <= KEY_NONE;
            rel_key_q    <= KEY_NONE;
            overflow_q   <= 1'b0;
            vs_d_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            candidate_q  <= candidate_d;
            stable_cnt_q <= stable_cnt_d;
            prev_key_q   <= prev_key_d;
            new_key_q    <= new_key_d;
            rel_key_q    <= rel_key_d;
            overflow_q   <= overflow_d;
            vs_d_q       <= vs;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (key_evt_t)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (evt_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (evt_count)
    );

    // Head event is masked to zero when nothing is queued.
    assign evt_valid   = !fifo_empty;
    assign evt_press   = evt_valid ? fifo_dout.press : 1'b0;
    assign evt_code    = evt_valid ? fifo_dout.code  : KEY_NONE;
    // The debounced key is exactly the last accepted value.
    assign held_key    = prev_key_q;
    assign overflow    = overflow_q;
    // vs_d_q resets low, so a low vs right after reset cannot fake an edge.
    assign frame_pulse = vs_d_q & ~vs;

endmodule
